// File: rtl/spi_inert_resp.sv
// SPI mode-0 responder standing in for the inertial sensor: decodes 16-bit
// frames from the on-chip master, serves a small register file and raises INT on new yaw data.
module spi_inert_resp #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic        smpl_vld,
    input  logic [15:0] smpl_yaw,
    output logic        setup_done,
    output logic        frame_err
);

    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SYNC_STAGES);

    typedef enum logic [1:0] {
        S_UNARMED = 2'b00,
        S_ARMED   = 2'b01,
        S_FRAME   = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] ss_sync_r, sclk_sync_r, mosi_sync_r;
    logic                   ss_d_r, sclk_d_r;
    logic [SW-1:0]          settle_r;
    state_t                 state_r, state_s;
    logic                   start_s, end_s;

    logic [4:0]  cnt_r;
    logic [15:0] rx_r;
    logic [7:0]  tx_r;
    logic        rd_r;
    logic        miso_r;

    logic [7:0]  int1_ctrl_r, ctrl2_g_r, ctrl5_c_r;
    logic [15:0] yaw_r, pend_r;
    logic        pend_vld_r;
    logic        int_r, setup_done_r, frame_err_r;

    logic        ss_s, sclk_s, mosi_s;
    logic        ss_rise_s, ss_fall_s, sclk_rise_s, sclk_fall_s;
    logic        settled_s, in_frame_s;
    logic [6:0]  rd_addr_s;
    logic [7:0]  rd_data_s;
    logic        commit_s, err_s, wr_s, rd_clr_s;
    logic        accept_s, load_s;
    logic [15:0] load_val_s;
    logic        int_s;

    assign ss_s        = ss_sync_r[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign ss_rise_s   = ss_s & ~ss_d_r;
    assign ss_fall_s   = ~ss_s & ss_d_r;
    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign settled_s   = (settle_r == SETTLE_MAX);
    assign in_frame_s  = (state_r == S_FRAME);
    assign rd_addr_s   = {rx_r[5:0], mosi_s};

    // Pin synchronizers and edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            ss_d_r      <= 1'b1;
            sclk_d_r    <= 1'b0;
        end else begin
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], SS_n};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
            ss_d_r      <= ss_s;
            sclk_d_r    <= sclk_s;
        end
    end

    // Arming waits until the synchronizers hold real pin values, so a low SS_n at reset exit is not a frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_r <= {SW{1'b0}};
        end else if (!settled_s) begin
            settle_r <= settle_r + SW'(1);
        end
    end

    // Frame-control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_UNARMED;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame-control next state and start/end strobes
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        end_s   = 1'b0;
        case (state_r)
            S_UNARMED: begin
                if (settled_s && ss_s) begin
                    state_s = S_ARMED;
                end else begin
                    state_s = S_UNARMED;
                end
            end
            S_ARMED: begin
                if (ss_fall_s) begin
                    state_s = S_FRAME;
                    start_s = 1'b1;
                end else begin
                    state_s = S_ARMED;
                end
            end
            S_FRAME: begin
                if (ss_rise_s) begin
                    state_s = S_ARMED;
                    end_s   = 1'b1;
                end else begin
                    state_s = S_FRAME;
                end
            end
            default: begin
                state_s = S_UNARMED;
            end
        endcase
    end

    // Register read mux, sampled at the 8th SCLK rise
    always_comb begin
        rd_data_s = 8'h00;
        case (rd_addr_s)
            7'h0F:   rd_data_s = WHO_AM_I_VAL;
            7'h0D:   rd_data_s = int1_ctrl_r;
            7'h11:   rd_data_s = ctrl2_g_r;
            7'h14:   rd_data_s = ctrl5_c_r;
            7'h26:   rd_data_s = yaw_r[7:0];
            7'h27:   rd_data_s = yaw_r[15:8];
            default: rd_data_s = 8'h00;
        endcase
    end

    // Shift path: bit counter, rx shifter, tx shifter and MISO
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= 5'd0;
            rx_r   <= 16'h0000;
            tx_r   <= 8'h00;
            rd_r   <= 1'b0;
            miso_r <= 1'b0;
        end else if (start_s) begin
            cnt_r  <= 5'd0;
            rx_r   <= 16'h0000;
            tx_r   <= 8'h00;
            rd_r   <= 1'b0;
            miso_r <= 1'b0;
        end else if (!in_frame_s || ss_s) begin
            miso_r <= 1'b0;
        end else if (sclk_rise_s) begin
            rx_r <= {rx_r[14:0], mosi_s};
            if (cnt_r < 5'd17) begin
                cnt_r <= cnt_r + 5'd1;
            end
            if (cnt_r == 5'd7) begin
                tx_r <= rd_data_s;
                rd_r <= rx_r[6];
            end
        end else if (sclk_fall_s) begin
            if (rd_r && (cnt_r >= 5'd8) && (cnt_r <= 5'd15)) begin
                miso_r <= tx_r[7];
                tx_r   <= {tx_r[6:0], 1'b0};
            end else begin
                miso_r <= 1'b0;
            end
        end
    end

    // Commit decision, sample acceptance and INT next value
    always_comb begin
        commit_s   = end_s && (cnt_r == 5'd16);
        err_s      = end_s && (cnt_r != 5'd16);
        wr_s       = commit_s && !rx_r[15];
        rd_clr_s   = commit_s && rx_r[15] && (rx_r[14:8] == 7'h27);
        accept_s   = smpl_vld && int1_ctrl_r[1] && (ctrl2_g_r[7:4] != 4'h0);
        load_s     = 1'b0;
        load_val_s = pend_r;
        if (end_s) begin
            // A strobe landing on the closing cycle is newer than anything pending
            load_s     = accept_s || pend_vld_r;
            load_val_s = accept_s ? smpl_yaw : pend_r;
        end else if (!in_frame_s) begin
            load_s     = accept_s;
            load_val_s = smpl_yaw;
        end else begin
            load_s     = 1'b0;
            load_val_s = pend_r;
        end
        if (load_s) begin
            int_s = 1'b1;
        end else if (rd_clr_s) begin
            int_s = 1'b0;
        end else begin
            int_s = int_r;
        end
    end

    // Register file, yaw/pending buffer and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            int1_ctrl_r  <= 8'h00;
            ctrl2_g_r    <= 8'h00;
            ctrl5_c_r    <= 8'h00;
            yaw_r        <= 16'h0000;
            pend_r       <= 16'h0000;
            pend_vld_r   <= 1'b0;
            int_r        <= 1'b0;
            setup_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (wr_s) begin
                case (rx_r[14:8])
                    7'h0D:   int1_ctrl_r <= rx_r[7:0];
                    7'h11:   ctrl2_g_r   <= rx_r[7:0];
                    7'h14:   ctrl5_c_r   <= rx_r[7:0];
                    default: ;
                endcase
            end
            if (wr_s && (rx_r[14:8] == 7'h0D) && rx_r[1]) begin
                setup_done_r <= 1'b1;
            end
            if (load_s) begin
                yaw_r <= load_val_s;
            end
            if (end_s) begin
                pend_vld_r <= 1'b0;
            end else if (in_frame_s && accept_s) begin
                pend_vld_r <= 1'b1;
                pend_r     <= smpl_yaw;
            end
            int_r       <= int_s;
            frame_err_r <= err_s;
        end
    end

    assign MISO       = miso_r;
    assign INT        = int_r;
    assign setup_done = setup_done_r;
    assign frame_err  = frame_err_r;

endmodule
